ram_arbiter_2p: RTL

- Two-requester arbiter/scheduler sharing a single ram8k16 (8K x 16, single port) between requester 0 and requester 1.
- Each clock it grants at most one requester and muxes that requester's wr/addr/data onto the RAM port.
- Tracks outstanding reads so returned RAM data is steered back to its issuer with a valid pulse.
- Sits between two bus masters (e.g. FIFO drain and APB/AXI bridge) and the RAM.

---
 rtl/ram_arbiter_2p.sv | 116 +++++++++++
 1 files changed

// File: rtl/ram_arbiter_2p.sv
// Two-requester arbiter sharing one single-port RAM, with read-return steering.
// Bursts are capped at MAX_BURST consecutive grants while the other port waits.
//
// state (derived) | meaning
// IDLE            | run_cnt == 0, no grant last cycle (or after reset)
// OWN0            | last_owner == 0, run_cnt = grants in current run
// OWN1            | last_owner == 1, run_cnt = grants in current run
module ram_arbiter_2p #(
  parameter int AW        = 13,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_datain,
  input  logic [DW-1:0] ram_dataout
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic          last_owner;
  logic [CW-1:0] run_cnt;
  logic          any_gnt;
  logic          sel1;
  logic          rd_push;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_id;

  // From IDLE a tie goes to the port that did not own last, so the
  // reset value last_owner=1 hands the first tie to port 0.
  always_comb begin
    sel1 = 1'b0;
    if (req0 && req1) begin
      if (run_cnt == '0)
        sel1 = ~last_owner;
      else if (run_cnt < MAX_CNT)
        sel1 = last_owner;
      else
        sel1 = ~last_owner;
    end else begin
      sel1 = req1;
    end
  end

  assign any_gnt = (req0 || req1) && !reset;
  assign gnt0    = any_gnt && !sel1;
  assign gnt1    = any_gnt && sel1;
  assign ram_wr  = any_gnt && (sel1 ? wr1 : wr0);
  assign rd_push = any_gnt && !(sel1 ? wr1 : wr0);

  always_comb begin
    ram_addr   = addr0;
    ram_datain = wdata0;
    if (reset) begin
      ram_addr   = '0;
      ram_datain = '0;
    end else if (gnt1) begin
      ram_addr   = addr1;
      ram_datain = wdata1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= 1'b1;
      run_cnt    <= '0;
    end else if (!any_gnt) begin
      run_cnt <= '0;
    end else if (sel1 == last_owner) begin
      if (run_cnt != MAX_CNT)
        run_cnt <= run_cnt + 1'b1;
    end else begin
      last_owner <= sel1;
      run_cnt    <= CW'(1);
    end
  end

  // Stage 0 holds the newest read; the tail stage lines up with ram_dataout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v[0]  <= rd_push;
      pipe_id[0] <= sel1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign rvalid0 = pipe_v[RD_LAT-1] && !pipe_id[RD_LAT-1] && !reset;
  assign rvalid1 = pipe_v[RD_LAT-1] &&  pipe_id[RD_LAT-1] && !reset;
  assign rdata0  = ram_dataout;
  assign rdata1  = ram_dataout;

endmodule
